// File: rtl/backend_types.sv
// Backend-wide types shared by the CDB arbiter and its consumers:
// payload struct, requester indices and branch-mask helpers.
package backend_types;

  localparam int PHYS_REG_WIDTH = 6;
  localparam int ROB_ADDR_WIDTH = 5;
  localparam int COB_DEPTH      = 4;
  localparam int COB_ADDR_WIDTH = 2;

  typedef enum logic [1:0] {
    CDB_INT = 2'd0,
    CDB_MUD = 2'd1,
    CDB_BRA = 2'd2,
    CDB_MEM = 2'd3
  } cdb_req_e;

  typedef struct packed {
    logic [PHYS_REG_WIDTH-1:0] prd;
    logic [ROB_ADDR_WIDTH-1:0] rob_index;
    logic [31:0]               data;
    logic [COB_DEPTH-1:0]      branch_mask;
  } cdb_entry_t;

  // Clears one branch-dependency bit when a correctly predicted branch resolves.
  function automatic logic [COB_DEPTH-1:0] mask_clear(
    input logic [COB_DEPTH-1:0]      mask,
    input logic [COB_ADDR_WIDTH-1:0] tag,
    input logic                      en
  );
    logic [COB_DEPTH-1:0] res;
    res = mask;
    if (en) begin
      res[tag] = 1'b0;
    end else begin
      res = mask;
    end
    return res;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Writeback request ports, branch-resolution broadcast and CDB output
// bundled between the execution units and the CDB arbiter.
interface cdb_arbiter_if #(parameter int NUM_REQ = 4);

  logic [NUM_REQ-1:0]                      req_valid;
  backend_types::cdb_entry_t [NUM_REQ-1:0] req_entry;
  logic [NUM_REQ-1:0]                      req_ready;
  logic                                    brb_broadcast;
  logic [backend_types::COB_ADDR_WIDTH-1:0] brb_tag;
  logic                                    brb_clean;
  logic                                    brb_kill;
  logic                                    cdb_valid;
  backend_types::cdb_entry_t               cdb_entry;

  modport master (
    output req_valid, req_entry, brb_broadcast, brb_tag, brb_clean, brb_kill,
    input  req_ready, cdb_valid, cdb_entry
  );

  modport slave (
    input  req_valid, req_entry, brb_broadcast, brb_tag, brb_clean, brb_kill,
    output req_ready, cdb_valid, cdb_entry
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first eligible index at or after rr_ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   winner,
  output logic               any
);

  // Scan downward in priority order so the closest eligible index wins last.
  always_comb begin : scan
    logic [IDX_W-1:0] sel;
    grant  = '0;
    winner = '0;
    sel    = '0;
    any    = |elig;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sel    = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      winner = elig[sel] ? sel : winner;
    end
    grant[winner] = any;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter placing one writeback result per cycle on the CDB,
// squashing or cleaning results on branch-resolution broadcasts.
module cdb_arbiter
  import backend_types::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic          clk,
  input  logic          rst,
  cdb_arbiter_if.slave  bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic               kill_s;
  logic               clean_s;
  logic [NUM_REQ-1:0] elig_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [IDX_W-1:0]   winner_s;
  logic               any_s;
  cdb_entry_t         win_entry_s;

  logic [IDX_W-1:0]   rr_ptr_r;
  logic               out_valid_r;
  cdb_entry_t         out_entry_r;

  assign kill_s  = bus.brb_broadcast & bus.brb_kill;
  assign clean_s = bus.brb_broadcast & bus.brb_clean;

  // A requester whose result depends on the mispredicted branch cannot win.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig_s[i] = bus.req_valid[i] & ~(kill_s & bus.req_entry[i].branch_mask[bus.brb_tag]);
    end
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .elig   (elig_s),
    .rr_ptr (rr_ptr_r),
    .grant  (grant_s),
    .winner (winner_s),
    .any    (any_s)
  );

  // Winner payload with a same-cycle clean applied before it is registered.
  always_comb begin
    win_entry_s             = bus.req_entry[winner_s];
    win_entry_s.branch_mask = mask_clear(bus.req_entry[winner_s].branch_mask, bus.brb_tag, clean_s);
  end

  // Round-robin pointer and the CDB output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r    <= '0;
      out_valid_r <= 1'b0;
      out_entry_r <= '0;
    end else if (any_s) begin
      rr_ptr_r    <= (winner_s == IDX_W'(NUM_REQ - 1)) ? '0 : winner_s + IDX_W'(1);
      out_valid_r <= 1'b1;
      out_entry_r <= win_entry_s;
    end else begin
      out_valid_r <= 1'b0;
    end
  end

  // Grants are withheld during reset; the held result is squashed or cleaned
  // by a broadcast arriving while it sits on the bus.
  always_comb begin
    if (rst) begin
      bus.req_ready = '0;
    end else begin
      bus.req_ready = grant_s;
    end
    bus.cdb_valid             = out_valid_r & ~(kill_s & out_entry_r.branch_mask[bus.brb_tag]);
    bus.cdb_entry             = out_entry_r;
    bus.cdb_entry.branch_mask = mask_clear(out_entry_r.branch_mask, bus.brb_tag, clean_s);
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed reset sequence, a hand-computed
// vector table and a randomized run against a queue-free behavioural model.
`timescale 1ns/1ps
module tb_cdb_arbiter;
  import backend_types::*;

  localparam int N = 4;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_REQ(N)) bus ();

  cdb_arbiter #(.NUM_REQ(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  v;
    logic [15:0] masks;
    logic        bc;
    logic        kl;
    logic        cl;
    logic [1:0]  tag;
    logic [3:0]  exp_ready;
    logic        exp_cv;
    logic [5:0]  exp_prd;
    logic [3:0]  exp_mask;
  } vec_t;

  vec_t vecs [26];

  // model state
  int         m_ptr;
  bit         m_ov;
  cdb_entry_t m_oe;
  bit         pend [N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [5:0] prd, input logic [3:0] mask);
    cdb_entry_t e;
    e.prd         = prd;
    e.rob_index   = 5'(i);
    e.data        = 32'h0000_00A0 + 32'(prd);
    e.branch_mask = mask;
    bus.req_valid[i] = v;
    bus.req_entry[i] = e;
  endtask

  task automatic set_brb(input logic bc, input logic kl, input logic cl, input logic [1:0] tag);
    bus.brb_broadcast = bc;
    bus.brb_kill      = kl;
    bus.brb_clean     = cl;
    bus.brb_tag       = tag;
  endtask

  // Reference model: evaluates the current cycle's expected outputs, compares,
  // then advances to the state after the coming clock edge. Returns the winner or -1.
  task automatic model_cycle(output int w);
    bit         kill;
    bit         clean;
    logic [3:0] er;
    bit         ecv;
    cdb_entry_t ee;
    kill  = bus.brb_broadcast && bus.brb_kill;
    clean = bus.brb_broadcast && bus.brb_clean;
    w = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (w < 0 && bus.req_valid[j] && !(kill && bus.req_entry[j].branch_mask[bus.brb_tag]))
        w = j;
    end
    er = 4'b0000;
    if (w >= 0) er[w] = 1'b1;
    chk("rand_req_ready", 64'(bus.req_ready), 64'(er));
    ecv = m_ov && !(kill && m_oe.branch_mask[bus.brb_tag]);
    chk("rand_cdb_valid", 64'(bus.cdb_valid), 64'(ecv));
    if (ecv) begin
      ee = m_oe;
      if (clean) ee.branch_mask[bus.brb_tag] = 1'b0;
      chk("rand_cdb_entry", 64'(bus.cdb_entry), 64'(ee));
    end
    if (w >= 0) begin
      m_oe = bus.req_entry[w];
      if (clean) m_oe.branch_mask[bus.brb_tag] = 1'b0;
      m_ov  = 1'b1;
      m_ptr = (w + 1) % N;
    end else begin
      m_ov = 1'b0;
    end
  endtask

  initial begin
    int w;
    bit kill_now;

    // ---- vector table: {valid, masks(req3..req0), bc, kill, clean, tag, ready, cv, prd, mask}
    vecs[0]  = '{4'b1111, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0, 6'd0,  4'h0};
    vecs[1]  = '{4'b1110, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0010, 1'b1, 6'd10, 4'h0};
    vecs[2]  = '{4'b1100, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b1, 6'd11, 4'h0};
    vecs[3]  = '{4'b1000, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b1000, 1'b1, 6'd12, 4'h0};
    vecs[4]  = '{4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 6'd13, 4'h0};
    vecs[5]  = '{4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 6'd0,  4'h0};
    vecs[6]  = '{4'b0010, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0010, 1'b0, 6'd0,  4'h0};
    vecs[7]  = '{4'b1010, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b1000, 1'b1, 6'd11, 4'h0};
    vecs[8]  = '{4'b1010, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0010, 1'b1, 6'd13, 4'h0};
    vecs[9]  = '{4'b1010, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b1000, 1'b1, 6'd11, 4'h0};
    vecs[10] = '{4'b1010, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0010, 1'b1, 6'd13, 4'h0};
    vecs[11] = '{4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 6'd11, 4'h0};
    vecs[12] = '{4'b1000, 16'h4000, 1'b1, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b0, 6'd0,  4'h0};
    vecs[13] = '{4'b1100, 16'h4000, 1'b1, 1'b1, 1'b0, 2'd2, 4'b0100, 1'b0, 6'd0,  4'h0};
    vecs[14] = '{4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 6'd12, 4'h0};
    vecs[15] = '{4'b0001, 16'h0002, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0001, 1'b0, 6'd0,  4'h0};
    vecs[16] = '{4'b0000, 16'h0000, 1'b1, 1'b1, 1'b0, 2'd1, 4'b0000, 1'b0, 6'd0,  4'h0};
    vecs[17] = '{4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 6'd0,  4'h0};
    vecs[18] = '{4'b0010, 16'h0060, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b0, 6'd0,  4'h0};
    vecs[19] = '{4'b0000, 16'h0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0000, 1'b1, 6'd11, 4'h0};
    vecs[20] = '{4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 6'd0,  4'h0};
    vecs[21] = '{4'b0100, 16'h0100, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0100, 1'b0, 6'd0,  4'h0};
    vecs[22] = '{4'b1001, 16'h1000, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0001, 1'b0, 6'd0,  4'h0};
    vecs[23] = '{4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 6'd10, 4'h0};
    vecs[24] = '{4'b0010, 16'h0040, 1'b1, 1'b1, 1'b0, 2'd1, 4'b0010, 1'b0, 6'd0,  4'h0};
    vecs[25] = '{4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 6'd11, 4'h4};

    // ---- reset and async mid-cycle reset
    rst = 1'b1;
    set_brb(1'b0, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 6'(10 + i), 4'h0);
    @(negedge clk);
    chk("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_cdb_entry", 64'(bus.cdb_entry), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 64'(bus.req_ready), 64'h1);
    @(negedge clk);
    chk("burst_ready", 64'(bus.req_ready), 64'h2);
    chk("burst_cdb_valid", 64'(bus.cdb_valid), 64'd1);
    chk("burst_cdb_prd", 64'(bus.cdb_entry.prd), 64'd10);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
    chk("async_rst_req_ready", 64'(bus.req_ready), 64'd0);
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 6'd0, 4'h0);
    set_req(int'(CDB_INT), 1'b1, 6'd5, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("int_ready_N", 64'(bus.req_ready), 64'h1);
    chk("int_cdb_idle_N", 64'(bus.cdb_valid), 64'd0);
    @(posedge clk);
    #1;
    set_req(int'(CDB_INT), 1'b0, 6'd0, 4'h0);
    @(negedge clk);
    chk("int_cdb_valid_N1", 64'(bus.cdb_valid), 64'd1);
    chk("int_cdb_prd_N1", 64'(bus.cdb_entry.prd), 64'd5);
    chk("int_ready_N1", 64'(bus.req_ready), 64'd0);

    // ---- table-driven vectors from a fresh reset
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int t = 0; t < 26; t++) begin
      for (int i = 0; i < N; i++) set_req(i, vecs[t].v[i], 6'(10 + i), vecs[t].masks[4*i +: 4]);
      set_brb(vecs[t].bc, vecs[t].kl, vecs[t].cl, vecs[t].tag);
      @(negedge clk);
      chk($sformatf("vec%0d_ready", t), 64'(bus.req_ready), 64'(vecs[t].exp_ready));
      chk($sformatf("vec%0d_cdb_valid", t), 64'(bus.cdb_valid), 64'(vecs[t].exp_cv));
      if (vecs[t].exp_cv) begin
        chk($sformatf("vec%0d_prd", t), 64'(bus.cdb_entry.prd), 64'(vecs[t].exp_prd));
        chk($sformatf("vec%0d_mask", t), 64'(bus.cdb_entry.branch_mask), 64'(vecs[t].exp_mask));
        chk($sformatf("vec%0d_data", t), 64'(bus.cdb_entry.data), 64'(32'h0000_00A0 + 32'(vecs[t].exp_prd)));
      end
      @(posedge clk);
      #1;
    end

    // ---- randomized run against the reference model
    rst = 1'b1;
    set_brb(1'b0, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < N; i++) begin
      set_req(i, 1'b0, 6'd0, 4'h0);
      pend[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    rst   = 1'b0;
    m_ptr = 0;
    m_ov  = 1'b0;
    m_oe  = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
          cdb_entry_t e;
          e.prd         = 6'($urandom_range(0, 63));
          e.rob_index   = 5'($urandom_range(0, 31));
          e.data        = $urandom;
          e.branch_mask = 4'($urandom & $urandom);
          bus.req_entry[i] = e;
          pend[i] = 1'b1;
        end
        bus.req_valid[i] = pend[i];
      end
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 0) set_brb(1'b1, 1'b1, 1'b0, 2'($urandom_range(0, 3)));
        else                           set_brb(1'b1, 1'b0, 1'b1, 2'($urandom_range(0, 3)));
      end else begin
        set_brb(1'b0, 1'b0, 1'b0, 2'($urandom_range(0, 3)));
      end
      @(negedge clk);
      model_cycle(w);
      kill_now = bus.brb_broadcast && bus.brb_kill;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (w == i) pend[i] = 1'b0;
        else if (pend[i] && kill_now && bus.req_entry[i].branch_mask[bus.brb_tag] && ($urandom_range(0, 1) == 1))
          pend[i] = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
